// File: rtl/inverse_substitution_layer_serial.sv
// Iterative inverse of the ASCON 5-bit S-box layer over a 320-bit state.
// Processes COLS_PER_CYCLE bit-sliced columns per clock, lowest column first,
// under a start/done handshake. Row 0 of the state holds the column MSB.
module inverse_substitution_layer_serial #(
  parameter int unsigned COLS_PER_CYCLE = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [0:4][63:0]  state_i,
  output logic [0:4][63:0]  state_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned N     = 64 / COLS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t              fsm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [0:4][63:0]  state_q;
  logic [0:4][63:0]  state_next;
  logic              busy_q;
  logic              done_q;
  logic [5:0]        col_idx;
  logic [4:0]        col_in;
  logic [4:0]        col_out;

  function automatic logic [4:0] inv_sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h14;  5'h01: y = 5'h1A;  5'h02: y = 5'h07;  5'h03: y = 5'h0D;
      5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0E;  5'h07: y = 5'h12;
      5'h08: y = 5'h0A;  5'h09: y = 5'h06;  5'h0A: y = 5'h1D;  5'h0B: y = 5'h01;
      5'h0C: y = 5'h19;  5'h0D: y = 5'h15;  5'h0E: y = 5'h13;  5'h0F: y = 5'h1E;
      5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0B;  5'h13: y = 5'h11;
      5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1C;  5'h17: y = 5'h1F;
      5'h18: y = 5'h17;  5'h19: y = 5'h1B;  5'h1A: y = 5'h04;  5'h1B: y = 5'h08;
      5'h1C: y = 5'h0F;  5'h1D: y = 5'h0C;  5'h1E: y = 5'h10;  default: y = 5'h02;
    endcase
    return y;
  endfunction

  // Inverse S-box applied to the slice of columns selected by the counter.
  always_comb begin
    state_next = state_q;
    col_idx    = '0;
    col_in     = '0;
    col_out    = '0;
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx = 6'(32'(cnt_q) * COLS_PER_CYCLE + k);
      col_in  = {state_q[0][col_idx], state_q[1][col_idx], state_q[2][col_idx],
                 state_q[3][col_idx], state_q[4][col_idx]};
      col_out = inv_sbox(col_in);
      state_next[0][col_idx] = col_out[4];
      state_next[1][col_idx] = col_out[3];
      state_next[2][col_idx] = col_out[2];
      state_next[3][col_idx] = col_out[1];
      state_next[4][col_idx] = col_out[0];
    end
  end

  // Control FSM with working register and registered busy/done flags.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= state_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_next;
          if (cnt_q == CNT_LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= state_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end else begin
            fsm_q <= IDLE;
          end
        end
        default: begin
          fsm_q  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_inverse_substitution_layer_serial.sv
// Bench for inverse_substitution_layer_serial: one instance per legal column
// width sharing stimulus; instance 3 (8 columns/cycle) carries timing checks.
module tb_inverse_substitution_layer_serial;

  typedef logic [0:4][63:0] st_t;

  localparam int NI = 7;
  localparam int MAIN = 3;
  localparam int unsigned CPC [NI] = '{1, 2, 4, 8, 16, 32, 64};

  // Forward ASCON S-box; the reference inverts it by searching for preimages.
  localparam logic [4:0] FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  st_t  state_i = '0;
  st_t  so_a   [NI];
  logic busy_a [NI];
  logic done_a [NI];

  int n_vec = 0;
  int n_err = 0;
  st_t res_all [NI];
  int  lat_all [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inverse_substitution_layer_serial #(.COLS_PER_CYCLE(CPC[g])) dut (
      .clock_i (clk),
      .reset_i (rst),
      .start_i (start_i),
      .state_i (state_i),
      .state_o (so_a[g]),
      .busy_o  (busy_a[g]),
      .done_o  (done_a[g])
    );
  end

  function automatic logic [4:0] get_col(input st_t s, input int j);
    return {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
  endfunction

  function automatic st_t put_col(input st_t s, input int j, input logic [4:0] v);
    st_t r = s;
    for (int r_i = 0; r_i < 5; r_i++) r[r_i][j] = v[4 - r_i];
    return r;
  endfunction

  function automatic st_t model_fwd(input st_t s);
    st_t r = '0;
    for (int j = 0; j < 64; j++) r = put_col(r, j, FWD[get_col(s, j)]);
    return r;
  endfunction

  function automatic st_t model_inv(input st_t s);
    st_t r = '0;
    for (int j = 0; j < 64; j++)
      for (int u = 0; u < 32; u++)
        if (FWD[u] == get_col(s, j)) r = put_col(r, j, 5'(u));
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses start for one edge from a negedge; returns at the negedge of cycle t+1.
  task automatic launch(input st_t v);
    start_i = 1'b1;
    state_i = v;
    @(negedge clk);
    start_i = 1'b0;
    state_i = rand_state();
  endtask

  task automatic run_main(input st_t v, output st_t res, output int lat, output int bcnt);
    launch(v);
    lat = -1;
    bcnt = 0;
    res = '0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (busy_a[MAIN]) bcnt++;
      if (done_a[MAIN]) begin
        lat = k;
        res = so_a[MAIN];
      end
      @(negedge clk);
    end
  endtask

  task automatic run_all(input st_t v);
    do_reset();
    @(negedge clk);
    launch(v);
    for (int i = 0; i < NI; i++) begin
      lat_all[i] = -1;
      res_all[i] = '0;
    end
    for (int k = 1; k <= 80; k++) begin
      for (int i = 0; i < NI; i++)
        if (done_a[i] && lat_all[i] < 0) begin
          lat_all[i] = k;
          res_all[i] = so_a[i];
        end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (so_a[i] !== '0 || busy_a[i] !== 1'b0 || done_a[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst%0d: state=%h busy=%b done=%b, required 0/0/0",
                 i, so_a[i], busy_a[i], done_a[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_constants();
    st_t res;
    int lat, bcnt;
    st_t exp0 = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};
    st_t exp1 = {64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0};
    @(negedge clk);
    run_main('0, res, lat, bcnt);
    n_vec++;
    if (res !== exp0) begin n_err++; $display("FAIL zeros_data: got %h, required %h", res, exp0); end
    n_vec++;
    if (lat !== 9) begin n_err++; $display("FAIL zeros_latency: got %0d, required 9", lat); end
    run_main('1, res, lat, bcnt);
    n_vec++;
    if (res !== exp1) begin n_err++; $display("FAIL ones_data: got %h, required %h", res, exp1); end
    n_vec++;
    if (bcnt !== 8) begin n_err++; $display("FAIL ones_busy_cycles: got %0d, required 8", bcnt); end
  endtask

  task automatic test_table();
    st_t v, res, exp;
    int lat, bcnt;
    int cols [3] = '{0, 31, 63};
    for (int c = 0; c < 3; c++)
      for (int val = 0; val < 32; val++) begin
        v = put_col('0, cols[c], 5'(val));
        exp = model_inv(v);
        run_main(v, res, lat, bcnt);
        n_vec++;
        if (res !== exp || lat !== 9) begin
          n_err++;
          $display("FAIL table col%0d val%0h: got %h lat %0d, required %h lat 9",
                   cols[c], val, res, lat, exp);
        end
      end
  endtask

  task automatic check_all(input string name, input st_t exp);
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (res_all[i] !== exp || lat_all[i] !== int'(64 / CPC[i]) + 1) begin
        n_err++;
        $display("FAIL %s C=%0d: got %h lat %0d, required %h lat %0d",
                 name, CPC[i], res_all[i], lat_all[i], exp, 64 / CPC[i] + 1);
      end
    end
  endtask

  task automatic test_roundtrip();
    st_t orig = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
                 64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    run_all(model_fwd(orig));
    check_all("roundtrip", orig);
  endtask

  task automatic test_random();
    st_t v;
    for (int n = 0; n < 4; n++) begin
      v = rand_state();
      run_all(v);
      check_all("random", model_inv(v));
    end
  endtask

  task automatic test_start_held();
    st_t a = rand_state();
    logic early = 1'b0;
    do_reset();
    @(negedge clk);
    start_i = 1'b1;
    state_i = a;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      if (done_a[MAIN]) early = 1'b1;
      state_i = rand_state();
      if (k == 8) start_i = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (early !== 1'b0 || done_a[MAIN] !== 1'b1 || so_a[MAIN] !== model_inv(a)) begin
      n_err++;
      $display("FAIL start_held: early=%b done=%b got %h, required 0/1 %h",
               early, done_a[MAIN], so_a[MAIN], model_inv(a));
    end
    @(negedge clk);
    n_vec++;
    if (done_a[MAIN] !== 1'b0 || busy_a[MAIN] !== 1'b0) begin
      n_err++;
      $display("FAIL start_held_idle: done=%b busy=%b, required 0/0", done_a[MAIN], busy_a[MAIN]);
    end
  endtask

  task automatic test_back_to_back();
    st_t a = rand_state();
    st_t b = rand_state();
    int k;
    do_reset();
    @(negedge clk);
    launch(a);
    k = 1;
    while (!done_a[MAIN] && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (k !== 9 || so_a[MAIN] !== model_inv(a)) begin
      n_err++;
      $display("FAIL b2b_first: lat %0d got %h, required lat 9 %h", k, so_a[MAIN], model_inv(a));
    end
    launch(b);
    n_vec++;
    if (busy_a[MAIN] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_no_gap: busy=%b, required 1", busy_a[MAIN]);
    end
    k = 1;
    while (!done_a[MAIN] && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (k !== 9 || so_a[MAIN] !== model_inv(b)) begin
      n_err++;
      $display("FAIL b2b_second: lat %0d got %h, required lat 9 %h", k, so_a[MAIN], model_inv(b));
    end
  endtask

  task automatic test_reset_abort();
    st_t v = rand_state();
    st_t res;
    int lat, bcnt;
    logic seen = 1'b0;
    do_reset();
    @(negedge clk);
    launch(v);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (so_a[MAIN] !== '0 || busy_a[MAIN] !== 1'b0 || done_a[MAIN] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: state=%h busy=%b done=%b, required 0/0/0",
               so_a[MAIN], busy_a[MAIN], done_a[MAIN]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done_a[MAIN]) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_done: done seen=%b, required 0", seen); end
    v = rand_state();
    run_main(v, res, lat, bcnt);
    n_vec++;
    if (res !== model_inv(v) || lat !== 9) begin
      n_err++;
      $display("FAIL abort_restart: got %h lat %0d, required %h lat 9", res, lat, model_inv(v));
    end
  endtask

  initial begin
    test_reset();
    test_constants();
    test_table();
    test_roundtrip();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inverse_substitution_layer_serial.md
# inverse_substitution_layer_serial

Iterative inverse of the ASCON 5-bit S-box layer: takes a 320-bit `type_state`, applies the inverse S-box to every bit-sliced column, and returns the state that the forward `substitution_layer` would map onto the input. It processes `COLS_PER_CYCLE` columns per clock under a start/done handshake. It sits beside the permutation datapath as a decryption-side and self-check resource, and is used to verify forward S-box results by round-trip.

## Interface

- `COLS_PER_CYCLE`, default 8: number of 5-bit columns inverted per clock.
  - Legal values: 1, 2, 4, 8, 16, 32, 64.
  - N = 64/`COLS_PER_CYCLE` compute cycles.
- `clock_i`, input, 1: single clock, rising edge.
- `reset_i`, input, 1: asynchronous, active-high reset.
- `start_i`, input, 1: request; sampled only in IDLE or DONE.
- `state_i`, input, `type_state` (5×64): state to invert; captured on the accepting edge.
- `state_o`, output, `type_state`: working register.
  - Holds the valid result from the `done_o` cycle until the next accepted start.
- `busy_o`, output, 1: high in RUN.
- `done_o`, output, 1: one-cycle pulse when the result is ready.

## Operation

- Column j (0..63) is the 5-bit value {x0,x1,x2,x3,x4} = {s[0][j],s[1][j],s[2][j],s[3][j],s[4][j]}, with x0 as the MSB. The result is written back to the same bit positions.
- Inverse S-box, input 0x00..0x1F maps to:
  - 0x00–0x0F: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E
  - 0x10–0x1F: 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02
- FSM states are IDLE, RUN, DONE.
  - IDLE: `start_i`=1 loads `state_i` into the register, clears cnt, and goes to RUN. `start_i`=0 stays in IDLE.
  - RUN: each edge replaces columns cnt·C .. cnt·C+C−1 (C = `COLS_PER_CYCLE`) with their inverse S-box values, then increments cnt.
    - When cnt = N−1, the same edge moves to DONE.
    - `start_i` is ignored in RUN.
  - DONE: `done_o`=1 for exactly this cycle.
    - The next edge goes to RUN (with reload) if `start_i`=1, else to IDLE.
- cnt width is clog2(N), minimum 1 bit. cnt never wraps within a job.
- Columns are processed LSB-first (column 0 first). Untouched columns keep their loaded value until processed.
- `state_i` changes after the accepting edge have no effect on the job.

## Timing

- Reset values: FSM=IDLE, cnt=0, register=all zero (`state_o`=0), `busy_o`=0, `done_o`=0.
- `reset_i` asserted mid-RUN or mid-DONE aborts the job immediately. No `done_o` is produced, and all outputs return to their reset values asynchronously.
- With `start_i` sampled high at the edge ending cycle t:
  - `busy_o` is high in cycles t+1..t+N.
  - `done_o` is high in cycle t+N+1.
  - Default N=8 gives `done_o` at t+9. C=64 gives t+2. C=1 gives t+65.
- Back-to-back operation: `start_i` high during the DONE cycle starts a new job with no idle gap. Throughput is one job per N+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Reset, then `start_i` with `state_i` all zero, C=8 → `done_o` at t+9. `state_o` = {FFFFFFFFFFFFFFFF, 0, FFFFFFFFFFFFFFFF, 0, 0} (0x00→0x14).
- `state_i` all ones → `state_o` = {0, 0, 0, FFFFFFFFFFFFFFFF, 0} (0x1F→0x02). `busy_o` is high for exactly 8 cycles.
- Round-trip with {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a}:
  - Drive `substitution_layer` with this vector and feed its output into this block.
  - `state_o` at `done_o` must equal the original vector, for each legal `COLS_PER_CYCLE`.
- Exhaustive table check: set column j to value v for every v=0..31 at j=0, 31, 63, other columns zero → column j equals the inverse table entry for v, other columns 0x14.
- `start_i` held high through RUN with a changing `state_i` → no restart and result from the first capture only. A `start_i` in the DONE cycle → `done_o` for the second job exactly N+1 cycles later.
- `reset_i` pulsed at cycle t+4 of a job → outputs zero immediately, no `done_o`. A fresh start afterwards completes with correct data.
